inst_prefetch: RTL and testbench

//  Instruction-fetch front end between the riscv core and the instruction rom.

---
 rtl/inst_prefetch_pkg.sv | 9 +
 rtl/inst_prefetch_sync_fifo.sv | 61 ++++++
 rtl/inst_prefetch.sv | 116 +++++++++++
 tb/tb_inst_prefetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_pkg.sv
// Shared fetch-path constants: instruction/address widths, boot PC and sequential PC step.
package inst_prefetch_pkg;

    localparam int          INST_W       = 32;
    localparam int          ADDR_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

endpackage

// File: rtl/inst_prefetch_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, a clear that wins over push/pop, and a combinational head.
import inst_prefetch_pkg::*;

module inst_prefetch_sync_fifo #(
    parameter int WIDTH = INST_W + ADDR_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q[PW-1:0]] = push_data_i;
                wr_ptr_d = wr_ptr_q + (PW+1)'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // The wrap bit makes the difference exact for both full (DEPTH) and empty (0).
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch: sequential PC issue to a 1-cycle ROM, credit-limited FIFO, flush/redirect.
// Optional INST_PREFETCH_PERF_EN adds a saturating decode-starvation counter on stall_cnt_o.
import inst_prefetch_pkg::*;

module inst_prefetch #(
    parameter int            DW       = INST_W,
    parameter int            AW       = ADDR_W,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic [AW-1:0] flush_pc_i,
    output logic [AW-1:0] rom_addr_o,
    output logic          rom_ren_o,
    input  logic [DW-1:0] rom_data_i,
    output logic          inst_valid_o,
    input  logic          inst_ready_i,
    output logic [DW-1:0] inst_o,
    output logic [AW-1:0] inst_pc_o
`ifdef INST_PREFETCH_PERF_EN
    ,
    output logic [31:0]   stall_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]    pc_q, pc_d;
    logic [AW-1:0]    iss_pc_q, iss_pc_d;
    logic             inflight_q, inflight_d;
    logic             drop_q, drop_d;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      occupancy;
    logic             issue;
    logic             push;
    logic             pop;
    logic [AW+DW-1:0] fifo_head;

    // Credit counts the outstanding read too, so its response always finds a free slot.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign issue     = !rst && !flush_i && (occupancy < (CW+1)'(DEPTH));
    assign push      = inflight_q && !drop_q && !flush_i;
    assign pop       = inst_valid_o && inst_ready_i && !flush_i;

    always_comb begin
        pc_d       = pc_q;
        iss_pc_d   = iss_pc_q;
        inflight_d = issue;
        drop_d     = 1'b0;
        if (flush_i) begin
            pc_d   = flush_pc_i;
            drop_d = inflight_q;
        end else if (issue) begin
            pc_d     = pc_q + AW'(PC_STEP);
            iss_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            iss_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            iss_pc_q   <= iss_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    inst_prefetch_sync_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({iss_pc_q, rom_data_i}),
        .pop_i       (pop),
        .clear_i     (flush_i),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign rom_addr_o   = pc_q;
    assign rom_ren_o    = issue;
    assign inst_valid_o = (fifo_count != '0);
    assign inst_o       = inst_valid_o ? fifo_head[DW-1:0] : '0;
    assign inst_pc_o    = inst_valid_o ? fifo_head[AW+DW-1:DW] : '0;

`ifdef INST_PREFETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (inst_ready_i && !inst_valid_o && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch; ROM model returns byte address + 0x100 one cycle after a read.
module tb_inst_prefetch;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic [AW-1:0] flush_pc_i = '0;
    logic [AW-1:0] rom_addr_o;
    logic          rom_ren_o;
    logic [DW-1:0] rom_data_i = '0;
    logic          inst_valid_o;
    logic          inst_ready_i = 1'b0;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] inst_pc_o;
`ifdef INST_PREFETCH_PERF_EN
    logic [31:0]   stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_ren_o) rom_data_i <= rom_addr_o + 32'h100;
    end

    inst_prefetch dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .rom_addr_o   (rom_addr_o),
        .rom_ren_o    (rom_ren_o),
        .rom_data_i   (rom_data_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o)
`ifdef INST_PREFETCH_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    task automatic do_reset(input logic rdy);
        rst = 1'b1; flush_i = 1'b0; inst_ready_i = rdy;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush_i = 1'b0; inst_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (rom_ren_o !== 1'b0) begin errors++; $display("FAIL rst_ren got=%0h exp=0", rom_ren_o); end
        checks++; if (rom_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", rom_addr_o); end
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", inst_valid_o); end
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst got=%0h exp=0", inst_o); end
        checks++; if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got=%0h exp=0", inst_pc_o); end
        rst = 1'b0; #1;
        checks++; if (rom_ren_o !== 1'b1 || rom_addr_o !== 32'h0) begin errors++; $display("FAIL first_issue ren=%0h addr=%0h exp ren=1 addr=0", rom_ren_o, rom_addr_o); end
        @(negedge clk); #1;
        checks++; if (rom_ren_o !== 1'b1 || rom_addr_o !== 32'h4 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL second_issue ren=%0h addr=%0h valid=%0h exp 1/4/0", rom_ren_o, rom_addr_o, inst_valid_o); end
        @(negedge clk); #1;
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h100 || inst_pc_o !== 32'h0) begin errors++; $display("FAIL first_head valid=%0h inst=%0h pc=%0h exp 1/100/0", inst_valid_o, inst_o, inst_pc_o); end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'(4*i) || inst_o !== 32'(4*i + 'h100)) begin
                errors++; $display("FAIL zero_bubble i=%0d valid=%0h pc=%0h inst=%0h exp pc=%0h", i, inst_valid_o, inst_pc_o, inst_o, 4*i);
            end
        end
    endtask

    task automatic test_stall;
        int n = 0;
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            if (rom_ren_o) n++;
            @(negedge clk); #1;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL stall_issue_count got=%0d exp=4", n); end
        checks++; if (rom_ren_o !== 1'b0 || rom_addr_o !== 32'h10) begin errors++; $display("FAIL stall_ren ren=%0h addr=%0h exp 0/10", rom_ren_o, rom_addr_o); end
        checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h100 || inst_pc_o !== 32'h0) begin errors++; $display("FAIL stall_head valid=%0h inst=%0h pc=%0h exp 1/100/0", inst_valid_o, inst_o, inst_pc_o); end
    endtask

    task automatic test_full_pop;
        inst_ready_i = 1'b1;
        @(negedge clk); #1;
        inst_ready_i = 1'b0;
        checks++; if (inst_pc_o !== 32'h4 || inst_o !== 32'h104) begin errors++; $display("FAIL one_pop pc=%0h inst=%0h exp 4/104", inst_pc_o, inst_o); end
        checks++; if (rom_ren_o !== 1'b1 || rom_addr_o !== 32'h10) begin errors++; $display("FAIL refill_issue ren=%0h addr=%0h exp 1/10", rom_ren_o, rom_addr_o); end
        @(negedge clk); #1;
        checks++; if (rom_ren_o !== 1'b0 || inst_pc_o !== 32'h4) begin errors++; $display("FAIL refill_credit ren=%0h pc=%0h exp 0/4", rom_ren_o, inst_pc_o); end
        @(negedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'(4 + 4*i)) begin
                errors++; $display("FAIL drain i=%0d valid=%0h pc=%0h exp pc=%0h", i, inst_valid_o, inst_pc_o, 4 + 4*i);
            end
            inst_ready_i = 1'b1;
            @(negedge clk); #1;
        end
        inst_ready_i = 1'b0;
    endtask

    task automatic test_flush_inflight;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        #1;
        flush_i = 1'b1; flush_pc_i = 32'h200; #1;
        checks++; if (rom_ren_o !== 1'b0) begin errors++; $display("FAIL flush_ren got=%0h exp=0", rom_ren_o); end
        @(negedge clk); #1;
        flush_i = 1'b0; #1;
        checks++; if (inst_valid_o !== 1'b0 || rom_ren_o !== 1'b1 || rom_addr_o !== 32'h200) begin errors++; $display("FAIL flush_f1 valid=%0h ren=%0h addr=%0h exp 0/1/200", inst_valid_o, rom_ren_o, rom_addr_o); end
        @(negedge clk); #1;
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL flush_stale valid=%0h pc=%0h exp valid=0", inst_valid_o, inst_pc_o); end
        @(negedge clk); #1;
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h200 || inst_o !== 32'h300) begin errors++; $display("FAIL flush_f2 valid=%0h pc=%0h inst=%0h exp 1/200/300", inst_valid_o, inst_pc_o, inst_o); end
        inst_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'(32'h200 + 4*i)) begin
                errors++; $display("FAIL post_flush i=%0d valid=%0h pc=%0h exp pc=%0h", i, inst_valid_o, inst_pc_o, 32'h200 + 4*i);
            end
        end
    endtask

    task automatic test_flush_pop;
        inst_ready_i = 1'b1;
        checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL fp_pre valid=%0h exp=1", inst_valid_o); end
        flush_i = 1'b1; flush_pc_i = 32'h400;
        @(negedge clk); #1;
        flush_i = 1'b0; #1;
        checks++; if (inst_valid_o !== 1'b0 || rom_ren_o !== 1'b1 || rom_addr_o !== 32'h400) begin errors++; $display("FAIL fp_empty valid=%0h ren=%0h addr=%0h exp 0/1/400", inst_valid_o, rom_ren_o, rom_addr_o); end
        @(negedge clk); #1;
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL fp_gap valid=%0h pc=%0h exp valid=0", inst_valid_o, inst_pc_o); end
        @(negedge clk); #1;
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h400 || inst_o !== 32'h500) begin errors++; $display("FAIL fp_head valid=%0h pc=%0h inst=%0h exp 1/400/500", inst_valid_o, inst_pc_o, inst_o); end
        inst_ready_i = 1'b0;
    endtask

    task automatic test_stream_random;
        int            got = 0;
        logic [AW-1:0] exp_pc = '0;
        logic          held = 1'b0;
        logic [AW-1:0] held_pc = '0;
        do_reset(1'b0);
        for (int cyc = 0; cyc < 400 && got < 13; cyc++) begin
            if (held) begin
                checks++;
                if (inst_valid_o !== 1'b1 || inst_pc_o !== held_pc) begin
                    errors++; $display("FAIL hold valid=%0h pc=%0h exp pc=%0h", inst_valid_o, inst_pc_o, held_pc);
                end
            end
            inst_ready_i = 1'($urandom_range(0, 1)); #1;
            if (inst_valid_o && inst_ready_i) begin
                checks++;
                if (inst_pc_o !== exp_pc || inst_o !== exp_pc + 32'h100) begin
                    errors++; $display("FAIL stream n=%0d pc=%0h inst=%0h exp pc=%0h", got, inst_pc_o, inst_o, exp_pc);
                end
                exp_pc = exp_pc + 32'h4;
                got++;
            end
            held = inst_valid_o && !inst_ready_i;
            held_pc = inst_pc_o;
            @(negedge clk); #1;
        end
        checks++; if (got != 13) begin errors++; $display("FAIL stream_count got=%0d exp=13", got); end
        inst_ready_i = 1'b0;
    endtask

    task automatic test_async_reset;
        inst_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        checks++; if (rom_ren_o !== 1'b0 || rom_addr_o !== 32'h0) begin errors++; $display("FAIL arst_rom ren=%0h addr=%0h exp 0/0", rom_ren_o, rom_addr_o); end
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || inst_pc_o !== 32'h0) begin errors++; $display("FAIL arst_head valid=%0h inst=%0h pc=%0h exp 0/0/0", inst_valid_o, inst_o, inst_pc_o); end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (rom_ren_o !== 1'b1 || rom_addr_o !== 32'h0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL arst_restart ren=%0h addr=%0h valid=%0h exp 1/0/0", rom_ren_o, rom_addr_o, inst_valid_o); end
        @(negedge clk); @(negedge clk); #1;
        checks++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0 || inst_o !== 32'h100) begin errors++; $display("FAIL arst_head2 valid=%0h pc=%0h inst=%0h exp 1/0/100", inst_valid_o, inst_pc_o, inst_o); end
        inst_ready_i = 1'b0;
    endtask

`ifdef INST_PREFETCH_PERF_EN
    task automatic test_perf;
        rst = 1'b1; flush_i = 1'b0; inst_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL perf_reset got=%0d exp=0", stall_cnt_o); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (stall_cnt_o !== 32'd2 || inst_valid_o !== 1'b1) begin errors++; $display("FAIL perf_count got=%0d valid=%0h exp 2/1", stall_cnt_o, inst_valid_o); end
        inst_ready_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_stall;
        test_full_pop;
        test_flush_inflight;
        test_flush_pop;
        test_stream_random;
        test_async_reset;
`ifdef INST_PREFETCH_PERF_EN
        test_perf;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
